// File: rtl/parent_link_hub_if.sv
// Leaf/root handshake bundle for the parent link hub.
// slave = hub side, master = leaves + root side.
`timescale 1ns/1ps
interface parent_link_hub_if #(
    parameter int NUM_LEAVES = 1,
    parameter int DATA_WIDTH = 64
);
    logic [NUM_LEAVES*DATA_WIDTH-1:0] leaf_tx_data;
    logic [NUM_LEAVES-1:0]            leaf_tx_valid;
    logic [NUM_LEAVES-1:0]            leaf_tx_ready;
    logic [NUM_LEAVES*DATA_WIDTH-1:0] leaf_rx_data;
    logic [NUM_LEAVES-1:0]            leaf_rx_valid;
    logic [NUM_LEAVES-1:0]            leaf_rx_ready;
    logic [DATA_WIDTH-1:0]            root_up_data;
    logic                             root_up_valid;
    logic                             root_up_ready;
    logic [DATA_WIDTH-1:0]            root_down_data;
    logic                             root_down_valid;
    logic                             root_down_ready;

    modport slave (
        input  leaf_tx_data, leaf_tx_valid,
        output leaf_tx_ready,
        output leaf_rx_data, leaf_rx_valid,
        input  leaf_rx_ready,
        output root_up_data, root_up_valid,
        input  root_up_ready,
        input  root_down_data, root_down_valid,
        output root_down_ready
    );

    modport master (
        output leaf_tx_data, leaf_tx_valid,
        input  leaf_tx_ready,
        input  leaf_rx_data, leaf_rx_valid,
        output leaf_rx_ready,
        input  root_up_data, root_up_valid,
        output root_up_ready,
        output root_down_data, root_down_valid,
        input  root_down_ready
    );
endinterface

// File: rtl/parent_link_hub.sv
// Root-side hub of the leaf parent link: round-robin credit-protected
// upstream merge through a fixed-latency link, and downstream routing.
`timescale 1ns/1ps
module parent_link_hub #(
    parameter int NUM_FPGAS    = 2,
    parameter int DATA_WIDTH   = 64,
    parameter int ROUTER_DELAY = 18,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                clk,
    input  logic                reset,
    parent_link_hub_if.slave    io_bus,
    output logic [15:0]         o_drop_count
);
    localparam int NL  = NUM_FPGAS - 1;
    localparam int LW  = (NL > 1) ? $clog2(NL) : 1;
    localparam int FAW = $clog2(FIFO_DEPTH);
    localparam int FCW = $clog2(FIFO_DEPTH + 1);
    localparam int IW  = $clog2(ROUTER_DELAY + 2);

    typedef enum logic {S_IDLE, S_DELIVER} state_t;

    function automatic logic [LW-1:0] f_wrap(input int v);
        return LW'(v % NL);
    endfunction

    // ---------------- upstream ----------------
    logic [LW-1:0]         r_ptr;
    logic [LW-1:0]         w_gidx;
    logic                  w_found;
    logic                  w_credit;
    logic [NL-1:0]         w_gnt;
    logic                  w_hs;
    logic [DATA_WIDTH-1:0] w_gdata;

    logic [ROUTER_DELAY:1] r_dv;
    logic [DATA_WIDTH-1:0] r_dd [1:ROUTER_DELAY];
    logic [IW-1:0]         r_infl;

    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [FAW-1:0]        r_wp;
    logic [FAW-1:0]        r_rp;
    logic [FCW-1:0]        r_fcnt;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_fvalid;

    // Credit covers everything already promised to the FIFO.
    assign w_credit = (int'(r_fcnt) + int'(r_infl)) < FIFO_DEPTH;

    // First valid leaf after the last winner.
    always_comb begin
        w_found = 1'b0;
        w_gidx  = '0;
        for (int k = 1; k <= NL; k++) begin
            if (!w_found && io_bus.leaf_tx_valid[f_wrap(int'(r_ptr) + k)]) begin
                w_found = 1'b1;
                w_gidx  = f_wrap(int'(r_ptr) + k);
            end
        end
    end

    // One-hot ready, only the winner and only with credit.
    always_comb begin
        w_gnt = '0;
        if (w_found && w_credit && !reset) begin
            w_gnt[w_gidx] = 1'b1;
        end
    end

    assign w_hs    = |w_gnt;
    assign w_gdata = io_bus.leaf_tx_data[int'(w_gidx)*DATA_WIDTH +: DATA_WIDTH];
    assign io_bus.leaf_tx_ready = w_gnt;

    // Round-robin pointer moves only on an accepted message.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr <= LW'(NL - 1);
        end else if (w_hs) begin
            r_ptr <= w_gidx;
        end
    end

    // Link valid bits always advance one stage per cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_dv <= '0;
        end else begin
            r_dv[1] <= w_hs;
            for (int k = 2; k <= ROUTER_DELAY; k++) begin
                r_dv[k] <= r_dv[k-1];
            end
        end
    end

    // Link payload follows its valid bit.
    always_ff @(posedge clk) begin
        r_dd[1] <= w_gdata;
        for (int k = 2; k <= ROUTER_DELAY; k++) begin
            r_dd[k] <= r_dd[k-1];
        end
    end

    // Messages currently travelling on the link.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_infl <= '0;
        end else begin
            r_infl <= r_infl + IW'(w_hs) - IW'(r_dv[ROUTER_DELAY]);
        end
    end

    assign w_push   = r_dv[ROUTER_DELAY];
    assign w_fvalid = (r_fcnt != '0);
    assign w_pop    = w_fvalid && io_bus.root_up_ready;

    // FIFO storage, written by the link exit.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wp] <= r_dd[ROUTER_DELAY];
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wp   <= '0;
            r_rp   <= '0;
            r_fcnt <= '0;
        end else begin
            r_wp   <= r_wp + FAW'(w_push);
            r_rp   <= r_rp + FAW'(w_pop);
            r_fcnt <= r_fcnt + FCW'(w_push) - FCW'(w_pop);
        end
    end

    assign io_bus.root_up_valid = w_fvalid;
    assign io_bus.root_up_data  = w_fvalid ? r_mem[r_rp] : '0;

    // ---------------- downstream ----------------
    state_t                r_state;
    logic [NL-1:0]         r_pend;
    logic [DATA_WIDTH-1:0] r_msg;
    logic [15:0]           r_drop;
    logic [7:0]            w_dest;
    logic [NL-1:0]         w_mask;
    logic [NL-1:0]         w_left;

    assign w_dest = io_bus.root_down_data[DATA_WIDTH-1 -: 8];
    assign w_left = r_pend & ~io_bus.leaf_rx_ready;

    // Destination decode: one leaf, all leaves, or nothing.
    always_comb begin
        w_mask = '0;
        if (w_dest == 8'hFF) begin
            w_mask = '1;
        end else if (w_dest != 8'd0 && int'(w_dest) <= NL) begin
            w_mask = NL'(1) << (w_dest - 8'd1);
        end
    end

    assign io_bus.root_down_ready = (r_state == S_IDLE) &&
                                    io_bus.root_down_valid && !reset;

    // Accept/drop root messages and track per-leaf delivery.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_pend  <= '0;
            r_msg   <= '0;
            r_drop  <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (io_bus.root_down_valid) begin
                        if (|w_mask) begin
                            r_pend  <= w_mask;
                            r_msg   <= io_bus.root_down_data;
                            r_state <= S_DELIVER;
                        end else if (r_drop != 16'hFFFF) begin
                            r_drop <= r_drop + 16'd1;
                        end
                    end
                end
                S_DELIVER: begin
                    r_pend <= w_left;
                    if (w_left == '0) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign io_bus.leaf_rx_valid = r_pend;
    assign io_bus.leaf_rx_data  = {NL{r_msg}};
    assign o_drop_count         = r_drop;
endmodule
